// File: rtl/regfile_wb.sv
// Register-file write-back arbiter: one write port shared by returning loads,
// a small in-order queue of deferred ALU results and a direct ALU bypass.
`ifndef XLEN
`define XLEN 32
`endif

module regfile_wb #(
  parameter int unsigned XLEN  = `XLEN,
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     alu_valid,
  input  logic [4:0]               alu_rd,
  input  logic [XLEN-1:0]          alu_data,
  output logic                     alu_ready,
  input  logic                     ld_valid,
  input  logic [4:0]               ld_rd,
  input  logic [XLEN-1:0]          ld_data,
  output logic                     wr_en,
  output logic [4:0]               rd,
  output logic [XLEN-1:0]          write_data,
  output logic [31:0]              busy_mask,
  output logic [$clog2(DEPTH):0]   q_count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [4:0]      q_rd   [DEPTH];
  logic [XLEN-1:0] q_data [DEPTH];
  logic [DEPTH-1:0] q_vld;
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;

  logic alu_take;
  logic alu_keep;
  logic q_empty;
  logic push;
  logic pop;
  logic bypass;
  logic [DEPTH-1:0] kill;

  assign alu_ready = (q_count < CW'(DEPTH));
  assign alu_take  = alu_valid & alu_ready;
  assign alu_keep  = alu_take & (alu_rd != 5'd0);
  assign q_empty   = (q_count == '0);

  // Loads own the port outright; the queue drains in order ahead of any bypass.
  assign pop    = ~ld_valid & ~q_empty;
  assign push   = alu_keep & (ld_valid | ~q_empty);
  assign bypass = alu_keep & ~ld_valid & q_empty;

  // A load is younger than anything already queued for the same register, so
  // those entries lose their write; the entry pushed this cycle is not affected.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    kill = '0;
    for (int i = 0; i < DEPTH; i++) begin
      kill[i] = ld_valid && (ld_rd != 5'd0) && q_vld[i] && (q_rd[i] == ld_rd);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_en      <= 1'b0;
      rd         <= 5'd0;
      write_data <= '0;
      q_count    <= '0;
      q_vld      <= '0;
      head       <= '0;
      tail       <= '0;
    end else begin
      if (ld_valid) begin
        wr_en      <= (ld_rd != 5'd0);
        rd         <= ld_rd;
        write_data <= ld_data;
      end else if (pop) begin
        wr_en      <= q_vld[head];
        rd         <= q_rd[head];
        write_data <= q_data[head];
      end else if (bypass) begin
        wr_en      <= 1'b1;
        rd         <= alu_rd;
        write_data <= alu_data;
      end else begin
        wr_en      <= 1'b0;
      end

      for (int i = 0; i < DEPTH; i++) begin
        if (kill[i]) q_vld[i] <= 1'b0;
      end

      if (pop) begin
        q_vld[head] <= 1'b0;
        head        <= head + PW'(1);
      end
      if (push) begin
        q_vld[tail] <= 1'b1;
        tail        <= tail + PW'(1);
      end

      q_count <= q_count + CW'(push) - CW'(pop);
    end
  end

  // NOTE: queue payload is not reset; q_vld alone says whether a slot is live.
  always_ff @(posedge clk) begin
    if (push) begin
      q_rd[tail]   <= alu_rd;
      q_data[tail] <= alu_data;
    end
  end

  always_comb begin
    busy_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (q_vld[i]) busy_mask[q_rd[i]] = 1'b1;
    end
    if (wr_en) busy_mask[rd] = 1'b1;
    busy_mask[0] = 1'b0;
  end

endmodule

// File: tb/tb_regfile_wb.sv
// Directed bench for regfile_wb: bypass, load/ALU collision, full queue,
// load-kills-queued-entry, x0 drop and reset in the middle of traffic.
module tb_regfile_wb;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic            alu_valid;
  logic [4:0]      alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            alu_ready;
  logic            ld_valid;
  logic [4:0]      ld_rd;
  logic [XLEN-1:0] ld_data;
  logic            wr_en;
  logic [4:0]      rd;
  logic [XLEN-1:0] write_data;
  logic [31:0]     busy_mask;
  logic [1:0]      q_count;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  regfile_wb #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .alu_valid  (alu_valid),
    .alu_rd     (alu_rd),
    .alu_data   (alu_data),
    .alu_ready  (alu_ready),
    .ld_valid   (ld_valid),
    .ld_rd      (ld_rd),
    .ld_data    (ld_data),
    .wr_en      (wr_en),
    .rd         (rd),
    .write_data (write_data),
    .busy_mask  (busy_mask),
    .q_count    (q_count)
  );

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic alu(input logic v, input logic [4:0] r, input logic [31:0] d);
    alu_valid = v;
    alu_rd    = r;
    alu_data  = d;
  endtask

  task automatic ld(input logic v, input logic [4:0] r, input logic [31:0] d);
    ld_valid = v;
    ld_rd    = r;
    ld_data  = d;
  endtask

  task automatic expect_write(input string tag, input logic [4:0] r, input logic [31:0] d);
    check({tag, ".wr_en"}, wr_en, 1'b1);
    check({tag, ".rd"}, rd, r);
    check({tag, ".data"}, write_data, d);
  endtask

  initial begin
    reset = 1'b0;
    alu(1'b0, 5'd0, 32'h0);
    ld(1'b0, 5'd0, 32'h0);
    tick();
    tick();

    check("rst.wr_en", wr_en, 1'b0);
    check("rst.rd", rd, 5'd0);
    check("rst.data", write_data, 32'h0);
    check("rst.q_count", q_count, 2'd0);
    check("rst.busy", busy_mask, 32'h0);
    check("rst.alu_ready", alu_ready, 1'b1);

    reset = 1'b1;
    tick();

    // Bypass straight to the port when the queue is empty.
    alu(1'b1, 5'd5, 32'hDEADBEEF);
    check("byp.ready", alu_ready, 1'b1);
    tick();
    alu(1'b0, 5'd0, 32'h0);
    expect_write("byp", 5'd5, 32'hDEADBEEF);
    check("byp.q_count", q_count, 2'd0);
    check("byp.busy", busy_mask, 32'h0000_0020);
    tick();
    check("byp.idle", wr_en, 1'b0);
    check("byp.idle_busy", busy_mask, 32'h0);

    // Load wins; the ALU result waits one cycle in the queue.
    ld(1'b1, 5'd3, 32'h11);
    alu(1'b1, 5'd7, 32'h22);
    tick();
    ld(1'b0, 5'd0, 32'h0);
    alu(1'b0, 5'd0, 32'h0);
    expect_write("col1", 5'd3, 32'h11);
    check("col1.q_count", q_count, 2'd1);
    check("col1.busy", busy_mask, 32'h0000_0088);
    tick();
    expect_write("col2", 5'd7, 32'h22);
    check("col2.q_count", q_count, 2'd0);
    check("col2.busy", busy_mask, 32'h0000_0080);
    tick();
    check("col3.wr_en", wr_en, 1'b0);

    // Three back-to-back loads fill the queue and hold off x10.
    ld(1'b1, 5'd20, 32'h120);
    alu(1'b1, 5'd8, 32'h8);
    check("full.ready0", alu_ready, 1'b1);
    tick();
    expect_write("full.a", 5'd20, 32'h120);
    check("full.a.q_count", q_count, 2'd1);
    ld(1'b1, 5'd21, 32'h121);
    alu(1'b1, 5'd9, 32'h9);
    tick();
    expect_write("full.b", 5'd21, 32'h121);
    check("full.b.q_count", q_count, 2'd2);
    check("full.b.ready", alu_ready, 1'b0);
    ld(1'b1, 5'd22, 32'h122);
    alu(1'b1, 5'd10, 32'hA);
    tick();
    expect_write("full.c", 5'd22, 32'h122);
    check("full.c.q_count", q_count, 2'd2);
    check("full.c.ready", alu_ready, 1'b0);
    check("full.c.busy", busy_mask, 32'h0040_0300);
    ld(1'b0, 5'd0, 32'h0);
    tick();
    expect_write("full.d", 5'd8, 32'h8);
    check("full.d.q_count", q_count, 2'd1);
    check("full.d.ready", alu_ready, 1'b1);
    tick();
    alu(1'b0, 5'd0, 32'h0);
    expect_write("full.e", 5'd9, 32'h9);
    check("full.e.q_count", q_count, 2'd1);
    tick();
    expect_write("full.f", 5'd10, 32'hA);
    check("full.f.q_count", q_count, 2'd0);
    tick();
    check("full.g.wr_en", wr_en, 1'b0);

    // x4 is queued, then a younger load to x4 kills it.
    ld(1'b1, 5'd12, 32'h33);
    alu(1'b1, 5'd4, 32'h44);
    tick();
    alu(1'b0, 5'd0, 32'h0);
    ld(1'b1, 5'd4, 32'h55);
    expect_write("kill.a", 5'd12, 32'h33);
    check("kill.a.q_count", q_count, 2'd1);
    tick();
    ld(1'b0, 5'd0, 32'h0);
    expect_write("kill.b", 5'd4, 32'h55);
    check("kill.b.q_count", q_count, 2'd1);
    check("kill.b.busy", busy_mask, 32'h0000_0010);
    tick();
    check("kill.c.wr_en", wr_en, 1'b0);
    check("kill.c.q_count", q_count, 2'd0);
    check("kill.c.busy", busy_mask, 32'h0);
    tick();
    check("kill.d.wr_en", wr_en, 1'b0);

    // Same-cycle load and ALU to x6: the ALU value lands last.
    ld(1'b1, 5'd6, 32'h60);
    alu(1'b1, 5'd6, 32'h61);
    tick();
    ld(1'b0, 5'd0, 32'h0);
    alu(1'b0, 5'd0, 32'h0);
    expect_write("same.a", 5'd6, 32'h60);
    check("same.a.q_count", q_count, 2'd1);
    tick();
    expect_write("same.b", 5'd6, 32'h61);
    check("same.b.q_count", q_count, 2'd0);

    // Writes to x0 from either source are dropped.
    ld(1'b1, 5'd0, 32'hEE);
    alu(1'b1, 5'd0, 32'hFF);
    tick();
    ld(1'b0, 5'd0, 32'h0);
    check("x0.a.wr_en", wr_en, 1'b0);
    check("x0.a.q_count", q_count, 2'd0);
    tick();
    alu(1'b0, 5'd0, 32'h0);
    check("x0.b.wr_en", wr_en, 1'b0);
    check("x0.b.q_count", q_count, 2'd0);
    check("x0.b.busy", busy_mask, 32'h0);

    // Fill the queue, then assert reset between clock edges.
    ld(1'b1, 5'd13, 32'h13);
    alu(1'b1, 5'd14, 32'h14);
    tick();
    ld(1'b1, 5'd15, 32'h15);
    alu(1'b1, 5'd16, 32'h16);
    tick();
    ld(1'b0, 5'd0, 32'h0);
    alu(1'b0, 5'd0, 32'h0);
    expect_write("mid.pre", 5'd15, 32'h15);
    check("mid.pre.q_count", q_count, 2'd2);
    #2;
    reset = 1'b0;
    #1;
    check("mid.rst.wr_en", wr_en, 1'b0);
    check("mid.rst.rd", rd, 5'd0);
    check("mid.rst.data", write_data, 32'h0);
    check("mid.rst.q_count", q_count, 2'd0);
    check("mid.rst.busy", busy_mask, 32'h0);
    check("mid.rst.ready", alu_ready, 1'b1);
    tick();
    #2;
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("mid.post.wr_en", wr_en, 1'b0);
      check("mid.post.q_count", q_count, 2'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
